// File: rtl/ln_pkg.sv
// Shared types and defaults for the layer-norm frame packer: state encoding,
// default frame geometry and the beat count of one frame.
package ln_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_SEQ_LEN    = 8;
   localparam int DEF_EMB_DIM    = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GAMMA,
      S_BETA,
      S_DATA,
      S_START,
      S_WAIT
   } ln_pack_state_t;

   // Gamma and beta vectors followed by the full activation matrix
   function automatic int frame_beats(input int seq_len, input int emb_dim);
      return 2 * emb_dim + seq_len * emb_dim;
   endfunction

endpackage

// File: rtl/ln_frame_packer.sv
// Assembles gamma, beta and the activation matrix from a beat-serial stream,
// starts the LN engine and holds the packed buses until its done is seen.
module ln_frame_packer
   import ln_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SEQ_LEN    = DEF_SEQ_LEN,
   parameter int EMB_DIM    = DEF_EMB_DIM
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic [DATA_WIDTH-1:0]                 s_data,
   input  logic                                  s_last,
   output logic                                  ln_start,
   input  logic                                  ln_done,
   output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] ln_x,
   output logic [DATA_WIDTH*EMB_DIM-1:0]         ln_gamma,
   output logic [DATA_WIDTH*EMB_DIM-1:0]         ln_beta,
   output logic                                  busy,
   output logic                                  err_len,
   output logic [15:0]                           frame_cnt
);

   localparam int COL_W = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1;
   localparam int ROW_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(EMB_DIM - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SEQ_LEN - 1);

   ln_pack_state_t   state;
   ln_pack_state_t   state_nxt;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             beat_acc;
   logic             col_wrap;
   logic             frame_end;
   logic             early_last;

   assign beat_acc   = s_valid && s_ready;
   assign col_wrap   = (col == COL_LAST);
   assign frame_end  = (state == S_DATA) && col_wrap && (row == ROW_LAST);
   assign early_last = beat_acc && s_last && !frame_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A premature s_last abandons the frame and restarts at gamma[0]
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_GAMMA;
         S_GAMMA: begin
            if (beat_acc) begin
               if (s_last)        state_nxt = S_GAMMA;
               else if (col_wrap) state_nxt = S_BETA;
            end
         end
         S_BETA: begin
            if (beat_acc) begin
               if (s_last)        state_nxt = S_GAMMA;
               else if (col_wrap) state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (beat_acc) begin
               if (frame_end)   state_nxt = S_START;
               else if (s_last) state_nxt = S_GAMMA;
            end
         end
         S_START: state_nxt = S_WAIT;
         S_WAIT:  if (ln_done) state_nxt = S_GAMMA;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      s_ready  = 1'b0;
      ln_start = 1'b0;
      busy     = 1'b0;
      case (state)
         S_GAMMA, S_BETA, S_DATA: s_ready = 1'b1;
         S_START: begin
            ln_start = 1'b1;
            busy     = 1'b1;
         end
         S_WAIT:  busy = 1'b1;
         default: ;
      endcase
   end

   // Buffers double as the output buses; they only change while s_ready is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         ln_x      <= '0;
         ln_gamma  <= '0;
         ln_beta   <= '0;
         err_len   <= 1'b0;
         frame_cnt <= '0;
      end else begin
         err_len <= 1'b0;
         if (state == S_START) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (state == S_WAIT && ln_done) begin
            col <= '0;
            row <= '0;
         end
         if (beat_acc) begin
            if (state == S_GAMMA) begin
               ln_gamma[int'(col)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            end else if (state == S_BETA) begin
               ln_beta[int'(col)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            end else begin
               ln_x[(int'(row)*EMB_DIM + int'(col))*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            end
            if (early_last) begin
               col     <= '0;
               row     <= '0;
               err_len <= 1'b1;
            end else begin
               col <= col_wrap ? '0 : col + 1'b1;
               if (state == S_DATA && col_wrap) begin
                  row <= (row == ROW_LAST) ? '0 : row + 1'b1;
               end
               if (frame_end && !s_last) begin
                  err_len <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ln_frame_packer.sv
// Randomised self-checking bench for ln_frame_packer; expected buses come from
// the list of beats sent, mapped onto gamma/beta/x by frame position.
module tb_ln_frame_packer;
   import ln_pkg::*;

   localparam int DW = DEF_DATA_WIDTH;
   localparam int SL = DEF_SEQ_LEN;
   localparam int ED = DEF_EMB_DIM;
   localparam int NB = frame_beats(SL, ED);

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  s_valid = 1'b0;
   logic                  s_ready;
   logic [DW-1:0]         s_data = '0;
   logic                  s_last = 1'b0;
   logic                  ln_start;
   logic                  ln_done = 1'b0;
   logic [DW*SL*ED-1:0]   ln_x;
   logic [DW*ED-1:0]      ln_gamma;
   logic [DW*ED-1:0]      ln_beta;
   logic                  busy;
   logic                  err_len;
   logic [15:0]           frame_cnt;

   int            n_checks = 0;
   int            n_fails = 0;
   int            start_count = 0;
   int            err_count = 0;
   int            exp_frames = 0;
   int            s0;
   int            e0;
   logic [DW-1:0] beats [NB];

   ln_frame_packer #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .EMB_DIM(ED)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .ln_start(ln_start), .ln_done(ln_done),
      .ln_x(ln_x), .ln_gamma(ln_gamma), .ln_beta(ln_beta), .busy(busy),
      .err_len(err_len), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ln_start) start_count++;
      if (err_len)  err_count++;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fillRandom();
      for (int i = 0; i < NB; i++) beats[i] = DW'($urandom);
   endtask

   task automatic fillPattern();
      for (int j = 0; j < ED; j++) begin
         beats[j]      = DW'(j + 1);
         beats[ED + j] = DW'(16'h0100 + j);
      end
      for (int r = 0; r < SL; r++)
         for (int c = 0; c < ED; c++)
            beats[2*ED + r*ED + c] = DW'(16'h1000 + 8*r + c);
   endtask

   // Sends beats[0..n_beats-1]; returns #1 after the edge accepting the last one
   task automatic applyStimulus(input int n_beats, input int last_idx, input int max_gap);
      bit got;
      int guard;
      for (int i = 0; i < n_beats; i++) begin
         int gap;
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (gap) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
         end
         s_valid = 1'b1;
         s_data  = beats[i];
         s_last  = (i == last_idx);
         got     = 1'b0;
         guard   = 0;
         while (!got && guard < 100) begin
            got = s_ready;
            @(posedge clk); #1;
            guard++;
         end
         if (!got) begin
            checkOutput("ready_timeout", 32'(s_ready), 32'd1);
            break;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic checkBuses(input string tag);
      for (int j = 0; j < ED; j++) begin
         checkOutput({tag, "_gamma"}, 32'(ln_gamma[j*DW +: DW]), 32'(beats[j]));
         checkOutput({tag, "_beta"},  32'(ln_beta[j*DW +: DW]),  32'(beats[ED + j]));
      end
      for (int r = 0; r < SL; r++)
         for (int c = 0; c < ED; c++)
            checkOutput({tag, "_x"}, 32'(ln_x[(r*ED + c)*DW +: DW]), 32'(beats[2*ED + r*ED + c]));
   endtask

   task automatic pulseDone();
      ln_done = 1'b1;
      @(posedge clk); #1;
      ln_done = 1'b0;
      checkOutput("done_ready", 32'(s_ready), 32'd1);
      checkOutput("done_busy",  32'(busy),    32'd0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_ready"}, 32'(s_ready),   32'd0);
      checkOutput({tag, "_start"}, 32'(ln_start),  32'd0);
      checkOutput({tag, "_busy"},  32'(busy),      32'd0);
      checkOutput({tag, "_err"},   32'(err_len),   32'd0);
      checkOutput({tag, "_cnt"},   32'(frame_cnt), 32'd0);
      checkOutput({tag, "_x"},     32'(|ln_x),     32'd0);
      checkOutput({tag, "_gamma"}, 32'(|ln_gamma), 32'd0);
      checkOutput({tag, "_beta"},  32'(|ln_beta),  32'd0);
   endtask

   initial begin
      $display("[TB] start: %0d beats per frame", NB);
      #23;
      checkResetValues("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Clean frame with the known pattern and no bubbles
      fillPattern();
      s0 = start_count;
      applyStimulus(NB, NB-1, 0);
      checkOutput("f1_start", 32'(ln_start), 32'd1);
      checkOutput("f1_busy",  32'(busy),     32'd1);
      checkOutput("f1_err",   32'(err_len),  32'd0);
      exp_frames++;
      @(posedge clk); #1;
      checkOutput("f1_start_once", 32'(ln_start),  32'd0);
      checkOutput("f1_cnt",        32'(frame_cnt), 32'(exp_frames));
      checkOutput("f1_x_r5c3",     32'(ln_x[(5*ED+3)*DW +: DW]), 32'h102B);
      checkOutput("f1_gamma0",     32'(ln_gamma[0 +: DW]), 32'd1);
      checkBuses("f1");

      // Beats offered while waiting on the engine must be refused
      for (int k = 0; k < 20; k++) begin
         s_valid = 1'b1;
         s_data  = DW'($urandom);
         s_last  = 1'($urandom);
         @(posedge clk); #1;
         checkOutput("bp_ready", 32'(s_ready), 32'd0);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      checkOutput("bp_busy", 32'(busy), 32'd1);
      checkBuses("bp_hold");
      ln_done = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_ready_after", 32'(s_ready), 32'd1);
      checkOutput("bp_busy_after",  32'(busy),    32'd0);
      @(posedge clk); #1;
      ln_done = 1'b0;
      checkOutput("bp_done_once", 32'(frame_cnt), 32'(exp_frames));
      checkOutput("bp_starts",    32'(start_count - s0), 32'd1);

      // Random data with random bubbles
      fillRandom();
      s0 = start_count;
      applyStimulus(NB, NB-1, 3);
      checkOutput("bub_start", 32'(ln_start), 32'd1);
      exp_frames++;
      @(posedge clk); #1;
      checkOutput("bub_cnt", 32'(frame_cnt), 32'(exp_frames));
      checkBuses("bub");
      repeat (5) @(posedge clk);
      #1;
      checkOutput("bub_starts", 32'(start_count - s0), 32'd1);
      pulseDone();

      // Early s_last on beat 30 drops the frame
      fillRandom();
      s0 = start_count;
      e0 = err_count;
      applyStimulus(30, 29, 2);
      checkOutput("early_err",   32'(err_len),  32'd1);
      checkOutput("early_start", 32'(ln_start), 32'd0);
      checkOutput("early_ready", 32'(s_ready),  32'd1);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("early_nostart", 32'(start_count - s0), 32'd0);
      checkOutput("early_errs",    32'(err_count - e0),   32'd1);
      fillRandom();
      applyStimulus(NB, NB-1, 1);
      checkOutput("clean_start", 32'(ln_start), 32'd1);
      checkOutput("clean_err",   32'(err_len),  32'd0);
      exp_frames++;
      @(posedge clk); #1;
      checkOutput("clean_cnt", 32'(frame_cnt), 32'(exp_frames));
      checkBuses("clean");
      pulseDone();

      // Missing s_last: frame still issued, err_len alongside start; done in S_START ignored
      fillRandom();
      applyStimulus(NB, -1, 0);
      checkOutput("nolast_start", 32'(ln_start), 32'd1);
      checkOutput("nolast_err",   32'(err_len),  32'd1);
      ln_done = 1'b1;
      @(posedge clk); #1;
      ln_done = 1'b0;
      exp_frames++;
      checkOutput("nolast_cnt", 32'(frame_cnt), 32'(exp_frames));
      @(posedge clk); #1;
      checkOutput("early_done_ignored", 32'(busy),    32'd1);
      checkOutput("wait_ready",         32'(s_ready), 32'd0);
      checkBuses("nolast");
      pulseDone();

      // Reset in the middle of the activation matrix
      fillRandom();
      applyStimulus(50, -1, 0);
      #2 rst_n = 1'b0;
      #1 checkResetValues("rst_data");
      exp_frames = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      s0 = start_count;
      ln_done = 1'b1;
      @(posedge clk); #1;
      ln_done = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_done_busy",  32'(busy),      32'd0);
      checkOutput("rst_done_ready", 32'(s_ready),   32'd1);
      checkOutput("rst_done_cnt",   32'(frame_cnt), 32'd0);
      fillRandom();
      applyStimulus(NB, NB-1, 1);
      checkOutput("rst_frame_start", 32'(ln_start), 32'd1);
      exp_frames++;
      @(posedge clk); #1;
      checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      checkBuses("rst_frame");

      // Reset while waiting for the engine
      #2 rst_n = 1'b0;
      #1 checkResetValues("rst_wait");
      exp_frames = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      s0 = start_count;
      ln_done = 1'b1;
      @(posedge clk); #1;
      ln_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstw_busy",   32'(busy),      32'd0);
      checkOutput("rstw_ready",  32'(s_ready),   32'd1);
      checkOutput("rstw_cnt",    32'(frame_cnt), 32'(exp_frames));
      checkOutput("rstw_starts", 32'(start_count - s0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/ln_frame_packer.md
Name: ln_frame_packer

Overview:
- Producer-side front end for the layer-normalisation engine.
- Accepts a beat-serial valid/ready element stream and assembles one frame: gamma vector, beta vector, then the SEQ_LEN x EMB_DIM activation matrix.
- Drives the flattened x/gamma/beta buses, pulses start, and holds the buses stable until the engine's done is seen.
- Sits between the token/activation stream source and the LN engine's start/done interface.

Parameters:
DATA_WIDTH, 16, bits per element (signed fixed-point, passed through untouched)
SEQ_LEN, 8, rows (tokens) per frame
EMB_DIM, 8, elements per row; also gamma/beta length

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_valid  in  1  input beat valid
s_ready  out  1  input beat ready
s_data  in  DATA_WIDTH  element value
s_last  in  1  marks final beat of a frame
ln_start  out  1  one-cycle start pulse to LN engine
ln_done  in  1  completion pulse from LN engine
ln_x  out  DATA_WIDTH*SEQ_LEN*EMB_DIM  flattened activations; element (r,c) at bits [(r*EMB_DIM+c)*DATA_WIDTH +: DATA_WIDTH]
ln_gamma  out  DATA_WIDTH*EMB_DIM  gamma j at [j*DATA_WIDTH +: DATA_WIDTH]
ln_beta  out  DATA_WIDTH*EMB_DIM  beta j, same packing
busy  out  1  high from start pulse until done seen
err_len  out  1  one-cycle pulse on frame-length violation
frame_cnt  out  16  frames issued (start pulses), wraps at 2^16

Behaviour:
- Reset (asynchronous, active-low): state S_IDLE; s_ready=0, ln_start=0, busy=0, err_len=0, frame_cnt=0; all buffers and beat counters=0.
- Frame layout: FRAME_BEATS = 2*EMB_DIM + SEQ_LEN*EMB_DIM (80 at defaults). Order: gamma[0..EMB_DIM-1], beta[0..EMB_DIM-1], x row 0 col 0..EMB_DIM-1, row 1, ... row-major.
- Beat accepted on posedge when s_valid && s_ready. s_ready is a decode of state: 1 only in S_GAMMA, S_BETA, S_DATA.
- States:
  - S_IDLE: leaves unconditionally to S_GAMMA the first cycle after reset release.
  - S_GAMMA: store beat to gamma[col]; col++; after beat EMB_DIM-1, col=0 and go to S_BETA.
  - S_BETA: same for beta; after the final beta beat, go to S_DATA.
  - S_DATA: store to x[row][col]; col wraps at EMB_DIM-1 with row++. After beat (SEQ_LEN-1, EMB_DIM-1), go to S_START.
  - S_START: ln_start=1 for exactly this cycle; frame_cnt++; go to S_WAIT.
  - S_WAIT: busy=1; on ln_done=1 go to S_GAMMA, clearing row/col.
- Latency: final data beat accepted at edge N; ln_start high in cycle N+1; s_ready returns one cycle after the edge that samples ln_done.
- ln_x, ln_gamma and ln_beta are the buffer registers, not registered copies. They are stable from S_START through S_WAIT, because no beats are accepted there.
- ln_done is ignored outside S_WAIT, including in the S_START cycle. Multi-cycle ln_done counts once.
- s_last rules:
  - s_last asserted on an accepted beat before the final beat: pulse err_len, discard the frame, return to S_GAMMA with counters cleared, issue no start. Buffer contents are then unspecified until refilled.
  - Final beat without s_last: frame is still issued normally; err_len pulses in the same cycle as ln_start.
- s_valid while s_ready=0 has no effect; s_data is not sampled.
- Reset mid-frame or mid-wait: immediate return to reset values. A pending ln_done after reset is ignored (state is not S_WAIT).
- frame_cnt 16'hFFFF + 1 -> 16'h0000.
- No arithmetic on data; values pass through bit-exact.

Decomposition:
- Shared package ln_pkg holds:
  - state typedef ln_pack_state_t (S_IDLE, S_GAMMA, S_BETA, S_DATA, S_START, S_WAIT)
  - default DATA_WIDTH/SEQ_LEN/EMB_DIM localparams
  - FRAME_BEATS function
- Row/col counter widths use $clog2 of the parameters, minimum 1.
- No sub-module: the block is a single FSM plus buffer registers.

Test Plan:
- Full frame, s_valid held high: gamma=1..8, beta=16'h0100..16'h0107, x(r,c)=16'h1000+8r+c, s_last on beat 80. Expect ln_start exactly one cycle after beat 80; ln_x[(5*8+3)*16 +:16]=16'h102B; ln_gamma[0+:16]=1; busy=1; frame_cnt=1.
- Backpressure and hold: in S_WAIT drive s_valid=1 with varying s_data for 20 cycles. Expect s_ready=0, buses unchanged. Pulse ln_done: expect s_ready=1 on the next cycle and busy=0.
- Bubbles: random s_valid gaps of 0-3 cycles across the frame. Expect the same packed buses as the first scenario and a single start pulse.
- Early s_last on beat 30: expect err_len pulse and no ln_start; a following clean frame issues start, with frame_cnt incremented by 1 only.
- Missing s_last on beat 80: expect ln_start and err_len high in the same cycle.
- rst_n low during S_DATA (beat 50) and separately during S_WAIT: expect all outputs at reset values asynchronously. A subsequent ln_done pulse produces no state change; a new frame is accepted from beat 1.
